bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//   Shares port B of the dual-port block RAM among NUM_REQ requesters; port A stays with the CPU.
//   Requester 0 is the VGA/sprite fetcher: real-time, fixed highest priority.
//   Requesters 1..NUM_REQ-1 (game-state updater, loader/debug) share the remaining slots round-robin.
//   A starvation limit caps how long requester 0 can monopolise the port.
//   Returns RAM read data tagged to the issuing requester one cycle after issue.
// PARAMETERS
//   DATA_WIDTH   16  RAM word width
//   ADDR_WIDTH   16  RAM address width
//   NUM_REQ      3   number of requesters, >=2
//   STARVE_LIMIT 8   max consecutive req0 grants while any other req is pending, >=1
// PORTS
//   clk        in   1                     single clock; all state updates on posedge
//   reset      in   1                     asynchronous, active-high
//   req        in   NUM_REQ               access request, one bit per requester
//   req_we     in   NUM_REQ               1 = write, 0 = read
//   req_addr   in   NUM_REQ*ADDR_WIDTH    packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  in   NUM_REQ*DATA_WIDTH    packed write data, same packing as req_addr
//   gnt        out  NUM_REQ               one-hot or zero; access performed at the edge where gnt[i]=1
//   rvalid     out  NUM_REQ               rdata valid for requester i (registered)
//   rdata      out  DATA_WIDTH            read data; = mem_q
//   mem_addr   out  ADDR_WIDTH            to RAM addr_b
//   mem_data   out  DATA_WIDTH            to RAM data_b
//   mem_we     out  1                     to RAM we_b
//   mem_q      in   DATA_WIDTH            from RAM q_b
// BEHAVIOUR
//   - Reset (async): rr_ptr=1, starve_cnt=0, mask0=0, rvalid=0. gnt=0 and mem_we=0 while reset is high.
//   - gnt is combinational from req and registered state. Grant selection:
//       req[0] && !mask0                         -> gnt[0]
//       else first requester with req set,
//         scanning from rr_ptr upward
//         over 1..NUM_REQ-1, wrapping to 1        -> that requester
//       no request                              -> gnt=0
//   - mem_addr/mem_data/mem_we are muxed combinationally from the granted requester.
//   - When gnt=0: mem_we=0 and mem_addr/mem_data hold 0.
//   - Requester rule: hold req, req_we, req_addr and req_wdata stable until a posedge with gnt[i]=1.
//     Drop req or change fields in the following cycle. One access per grant cycle.
//     Back-to-back grants to the same requester are allowed.
//   - Read latency: a read issued at edge N has rvalid[i]=1 during cycle N+1. rdata=mem_q that cycle.
//     rvalid[i] is a one-cycle pulse. Writes produce no rvalid.
//   - Write-then-read of the same address in consecutive grants returns the new data (RAM write-first).
//   - rr_ptr: after a grant to requester k>=1, rr_ptr <= k+1, wrapping from NUM_REQ-1 to 1.
//     Unchanged on a req0 grant or when idle.
//   - Starvation control:
//       req0 granted while any req[1..] is set -> starve_cnt++
//       otherwise                             -> starve_cnt <= 0
//       starve_cnt reaches STARVE_LIMIT       -> mask0 <= 1 for exactly one cycle, starve_cnt <= 0
//     While mask0=1:
//       some req[1..] set -> round-robin grant
//       no req[1..] set   -> req0 granted anyway (no idle slot wasted)
//   - Reset mid-read: pending rvalid is dropped. Requesters reissue after reset.
// TESTING
//   1 Reset pulse mid-traffic -> gnt=0, rvalid=0, mem_we=0 immediately (async); after release first grant follows priority.
//   2 Only req[2] read addr 0x00d5, RAM holds 0x0003 -> gnt=3'b100 that edge; next cycle rvalid=3'b100, rdata=0x0003.
//   3 req[1] and req[2] held continuously, req[0]=0 -> grants alternate 1,2,1,2 starting at 1.
//   4 req[0] and req[1] held, STARVE_LIMIT=8 -> 8 grants to 0, one grant to 1, then 8 more to 0; pattern repeats.
//   5 req[1] write 0x1234 to 0x00c8, then req[2] read 0x00c8 next cycle -> rvalid[2] with rdata=0x1234.
//   6 req[0] alone for 20 cycles -> 20 consecutive gnt[0]; starve_cnt stays 0, never masked.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Port-B arbiter for the shared block RAM: fixed-priority video fetcher,
// round-robin for the rest, with a starvation cap on requester 0.
module bram_port_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          mem_we,
  input  logic [DATA_WIDTH-1:0]         mem_q
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_next;
  logic [PW-1:0] idx;
  logic [CW-1:0] starve_cnt;
  logic          mask0;
  logic          found;
  logic          others;

  assign others = |req[NUM_REQ-1:1];
  assign rdata  = mem_q;

  always_comb begin
    gnt     = '0;
    rr_next = rr_ptr;
    found   = 1'b0;
    idx     = '0;
    if (req[0] && !mask0) begin
      gnt[0] = 1'b1;
    end else begin
      for (int o = 0; o < NUM_REQ - 1; o++) begin
        idx = PW'((int'(rr_ptr) - 1 + o) % (NUM_REQ - 1) + 1);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
          rr_next  = (idx == PW'(NUM_REQ - 1)) ? PW'(1) : idx + PW'(1);
        end
      end
      // masked slot with nobody else waiting still goes to the fetcher
      if (!found && req[0]) gnt[0] = 1'b1;
    end
    if (reset) begin
      gnt     = '0;
      rr_next = rr_ptr;
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_we   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_addr = mem_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_data = mem_data | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        mem_we   = mem_we | req_we[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= PW'(1);
      starve_cnt <= '0;
      mask0      <= 1'b0;
      rvalid     <= '0;
    end else begin
      rr_ptr <= rr_next;
      rvalid <= gnt & ~req_we;
      mask0  <= 1'b0;
      if (gnt[0] && others) begin
        if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
          mask0      <= 1'b1;
          starve_cnt <= '0;
        end else begin
          starve_cnt <= starve_cnt + CW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbiter/RAM model.
module tb_bram_port_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int N     = 3;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ram  [256];
  logic [DW-1:0] mref [256];

  logic [N-1:0]  a_req;
  logic [N-1:0]  a_we;
  logic [AW-1:0] a_addr  [N];
  logic [DW-1:0] a_wdata [N];

  int            m_rr;
  int            m_cnt;
  bit            m_mask;
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_rdata;

  bram_port_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_REQ     (N),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .mem_q    (mem_q)
  );

  always #5 clk = ~clk;

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req[i]                 = a_req[i];
      req_we[i]              = a_we[i];
      req_addr[i*AW +: AW]   = a_addr[i];
      req_wdata[i*DW +: DW]  = a_wdata[i];
    end
  endtask

  task automatic clear_agents();
    a_req = '0;
    a_we  = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i]  = '0;
      a_wdata[i] = '0;
    end
    pack();
  endtask

  // synchronous write-first RAM on port B
  task automatic tick();
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = mem_we;
    a = mem_addr;
    d = mem_data;
    @(posedge clk);
    if (w) ram[a[7:0]] = d;
    mem_q = w ? d : ram[a[7:0]];
    #1;
  endtask

  task automatic model_reset();
    m_rr   = 1;
    m_cnt  = 0;
    m_mask = 1'b0;
    m_rv   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_agents();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic int model_gnt(input logic [N-1:0] r);
    int k;
    if (r == '0) return -1;
    if (r[0] && !m_mask) return 0;
    for (int o = 0; o < N - 1; o++) begin
      k = (m_rr - 1 + o) % (N - 1) + 1;
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    a_req = '1;
    a_we  = '1;
    pack();
    #2;
    n_tests++;
    if (gnt !== '0 || rvalid !== '0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs gnt=%b rvalid=%b we=%b want 0", gnt, rvalid, mem_we);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    a_we = '0;
    pack();
    @(negedge clk);
    n_tests++;
    if (gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_first_gnt gnt=%b want 001", gnt);
    end
    tick();
    clear_agents();
  endtask

  task automatic test_single_read();
    do_reset();
    a_req[2]  = 1'b1;
    a_addr[2] = 16'h00d5;
    pack();
    @(negedge clk);
    n_tests++;
    if (gnt !== 3'b100 || mem_addr !== 16'h00d5 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue gnt=%b addr=%h we=%b want 100/00d5/0",
               gnt, mem_addr, mem_we);
    end
    tick();
    clear_agents();
    @(negedge clk);
    n_tests++;
    if (rvalid !== 3'b100 || rdata !== 16'h0003) begin
      n_fail++;
      $display("FAIL single_rdata rvalid=%b rdata=%h want 100/0003", rvalid, rdata);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (rvalid !== 3'b000) begin
      n_fail++;
      $display("FAIL single_pulse rvalid=%b want 000", rvalid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    do_reset();
    a_req = 3'b110;
    pack();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      eg = (c % 2 == 0) ? 3'b010 : 3'b100;
      n_tests++;
      if (gnt !== eg) begin
        n_fail++;
        $display("FAIL rr_alternate cycle=%0d gnt=%b want %b", c, gnt, eg);
      end
      tick();
    end
    clear_agents();
  endtask

  task automatic test_starvation();
    logic [N-1:0] eg;
    do_reset();
    a_req = 3'b011;
    pack();
    for (int c = 0; c < 2 * (LIMIT + 1); c++) begin
      @(negedge clk);
      eg = (c % (LIMIT + 1) == LIMIT) ? 3'b010 : 3'b001;
      n_tests++;
      if (gnt !== eg) begin
        n_fail++;
        $display("FAIL starve cycle=%0d gnt=%b want %b", c, gnt, eg);
      end
      tick();
    end
    clear_agents();
  endtask

  task automatic test_write_then_read();
    do_reset();
    a_req[1]   = 1'b1;
    a_we[1]    = 1'b1;
    a_addr[1]  = 16'h00c8;
    a_wdata[1] = 16'h1234;
    pack();
    @(negedge clk);
    n_tests++;
    if (gnt !== 3'b010 || mem_we !== 1'b1 || mem_data !== 16'h1234
        || mem_addr !== 16'h00c8) begin
      n_fail++;
      $display("FAIL wr_issue gnt=%b we=%b addr=%h data=%h want 010/1/00c8/1234",
               gnt, mem_we, mem_addr, mem_data);
    end
    tick();
    mref[8'hc8] = 16'h1234;
    clear_agents();
    a_req[2]  = 1'b1;
    a_addr[2] = 16'h00c8;
    pack();
    @(negedge clk);
    n_tests++;
    if (gnt !== 3'b100 || rvalid !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_then_rd_issue gnt=%b rvalid=%b want 100/000", gnt, rvalid);
    end
    tick();
    clear_agents();
    @(negedge clk);
    n_tests++;
    if (rvalid !== 3'b100 || rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL wr_then_rd_data rvalid=%b rdata=%h want 100/1234", rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_req0_alone();
    do_reset();
    a_req[0]  = 1'b1;
    a_addr[0] = 16'h0005;
    pack();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (gnt !== 3'b001) begin
        n_fail++;
        $display("FAIL req0_alone cycle=%0d gnt=%b want 001", c, gnt);
      end
      if (c > 0) begin
        n_tests++;
        if (rvalid !== 3'b001 || rdata !== mref[5]) begin
          n_fail++;
          $display("FAIL req0_rdata cycle=%0d rvalid=%b rdata=%h want 001/%h",
                   c, rvalid, rdata, mref[5]);
        end
      end
      tick();
    end
    clear_agents();
  endtask

  task automatic test_random();
    int            g;
    logic [N-1:0]  eg;
    logic          ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          oth;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g   = model_gnt(a_req);
      eg  = (g < 0) ? '0 : (N'(1) << g);
      ewe = (g < 0) ? 1'b0 : a_we[g];
      ea  = (g < 0) ? '0 : a_addr[g];
      ed  = (g < 0) ? '0 : a_wdata[g];
      n_tests++;
      if (gnt !== eg) begin
        n_fail++;
        $display("FAIL rand_gnt cycle=%0d gnt=%b want %b", c, gnt, eg);
      end
      n_tests++;
      if (mem_we !== ewe || mem_addr !== ea || mem_data !== ed) begin
        n_fail++;
        $display("FAIL rand_mux cycle=%0d we=%b addr=%h data=%h want %b/%h/%h",
                 c, mem_we, mem_addr, mem_data, ewe, ea, ed);
      end
      n_tests++;
      if (rvalid !== m_rv) begin
        n_fail++;
        $display("FAIL rand_rvalid cycle=%0d rvalid=%b want %b", c, rvalid, m_rv);
      end
      if (m_rv != '0) begin
        n_tests++;
        if (rdata !== m_rdata) begin
          n_fail++;
          $display("FAIL rand_rdata cycle=%0d rdata=%h want %h", c, rdata, m_rdata);
        end
      end
      oth  = |a_req[N-1:1];
      m_rv = '0;
      if (g >= 0) begin
        if (a_we[g]) begin
          mref[a_addr[g][7:0]] = a_wdata[g];
        end else begin
          m_rv[g] = 1'b1;
          m_rdata = mref[a_addr[g][7:0]];
        end
      end
      if (g >= 1) m_rr = g % (N - 1) + 1;
      if (g == 0 && oth) begin
        m_cnt++;
        m_mask = (m_cnt == LIMIT);
        if (m_mask) m_cnt = 0;
      end else begin
        m_cnt  = 0;
        m_mask = 1'b0;
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if ((a_req[i] && g == i) || !a_req[i]) begin
          a_req[i]   = ($urandom_range(0, 99) < ((i == 0) ? 55 : 65));
          a_we[i]    = $urandom_range(0, 1) == 1;
          a_addr[i]  = AW'($urandom_range(0, 15));
          a_wdata[i] = DW'($urandom);
        end
      end
      pack();
      if (c == 200) begin
        a_req[2]  = 1'b1;
        a_req[0]  = 1'b1;
        pack();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (gnt !== '0 || rvalid !== '0 || mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset gnt=%b rvalid=%b we=%b want 0", gnt, rvalid, mem_we);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
      end
    end
    clear_agents();
  endtask

  initial begin
    reset = 1'b1;
    mem_q = '0;
    for (int a = 0; a < 256; a++) begin
      ram[a]  = (a == 8'hd5) ? 16'h0003 : {8'ha5, 8'(a)};
      mref[a] = (a == 8'hd5) ? 16'h0003 : {8'ha5, 8'(a)};
    end
    clear_agents();
    test_reset();
    test_single_read();
    test_round_robin();
    test_starvation();
    test_write_then_read();
    test_req0_alone();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
